// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller for the dual-clock pointer FIFO: accepts producer words, drives the
// RAM write port, keeps binary/Gray write pointers and derives full, almost-full, level and overflow.
module async_fifo_wr_ctrl #(
   parameter int WIDTH        = 8,
   parameter int ADDR_W       = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic              in_clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              clr_ovf,
   input  logic [ADDR_W:0]   rptr_gray_async,
   output logic [ADDR_W:0]   wptr_gray,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              fifo_f,
   output logic              fifo_af,
   output logic [ADDR_W:0]   wr_level,
   output logic              overflow
);

   localparam logic [ADDR_W:0] AF_TH = AFULL_THRESH[ADDR_W:0];

   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b = g;
      for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [ADDR_W:0] wbin;
   logic [ADDR_W:0] rq1, rq2;
   logic [ADDR_W:0] rbin;
   logic [ADDR_W:0] wbin_next, wgray_next, lvl_next, full_gray;
   logic            push;

   assign push      = wr_en & ~fifo_f;
   assign mem_we    = push;
   assign mem_waddr = wbin[ADDR_W-1:0];
   assign mem_wdata = wr_data;

   assign rbin       = gray2bin(rq2);
   assign wbin_next  = wbin + {{ADDR_W{1'b0}}, push};
   assign wgray_next = wbin_next ^ (wbin_next >> 1);
   assign lvl_next   = wbin_next - rbin;
   // Write pointer is a full lap ahead of the read pointer: top two Gray bits inverted.
   assign full_gray  = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};

   always_ff @(posedge in_clk or posedge reset) begin
      if (reset) begin
         rq1       <= '0;
         rq2       <= '0;
         wbin      <= '0;
         wptr_gray <= '0;
         fifo_f    <= 1'b0;
         fifo_af   <= 1'b0;
         wr_level  <= '0;
         overflow  <= 1'b0;
      end else begin
         rq1       <= rptr_gray_async;
         rq2       <= rq1;
         wbin      <= wbin_next;
         wptr_gray <= wgray_next;
         fifo_f    <= (wgray_next == full_gray);
         fifo_af   <= (lvl_next >= AF_TH);
         wr_level  <= lvl_next;
         // Set wins over clear on the same edge.
         if (wr_en & fifo_f)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed scenarios then random traffic, checked against a
// count-based model (words written, reads made visible after two write-clock edges).
module tb_async_fifo_wr_ctrl;
   localparam int WIDTH = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH = 8;
   localparam int AFT = 6;

   logic             in_clk = 1'b0;
   logic             reset;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             clr_ovf;
   logic [ADDR_W:0]  rptr_gray_async;
   logic [ADDR_W:0]  wptr_gray;
   logic             mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic             fifo_f, fifo_af, overflow;
   logic [ADDR_W:0]  wr_level;

   async_fifo_wr_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_THRESH(AFT)) dut (
      .in_clk(in_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
      .rptr_gray_async(rptr_gray_async), .wptr_gray(wptr_gray), .mem_we(mem_we),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .fifo_f(fifo_f), .fifo_af(fifo_af),
      .wr_level(wr_level), .overflow(overflow)
   );

   always #5 in_clk = ~in_clk;

   int checks = 0;
   int errors = 0;

   // Model: total words accepted, total words read, read counts in flight through the synchroniser.
   int wcount, rcount, d1, d2;
   bit m_full, m_af, m_ovf;
   int m_level;

   function automatic logic [ADDR_W:0] to_gray(input int n);
      logic [ADDR_W:0] b;
      b = n[ADDR_W:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      wcount = 0; rcount = 0; d1 = 0; d2 = 0;
      m_full = 0; m_af = 0; m_ovf = 0; m_level = 0;
   endtask

   task automatic check_regs();
      chk("wptr_gray", 32'(wptr_gray), 32'(to_gray(wcount)));
      chk("fifo_f", 32'(fifo_f), 32'(m_full));
      chk("fifo_af", 32'(fifo_af), 32'(m_af));
      chk("wr_level", 32'(wr_level), 32'(m_level));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic step(input bit we, input logic [WIDTH-1:0] d, input bit clr);
      bit push;
      @(negedge in_clk);
      wr_en = we; wr_data = d; clr_ovf = clr;
      rptr_gray_async = to_gray(rcount);
      #1;
      push = we && !m_full;
      chk("mem_we", 32'(mem_we), 32'(push));
      if (push) begin
         chk("mem_waddr", 32'(mem_waddr), 32'(wcount % DEPTH));
         chk("mem_wdata", 32'(mem_wdata), 32'(d));
      end
      @(posedge in_clk);
      if (we && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (push) wcount++;
      m_level = wcount - d2;
      d2 = d1;
      d1 = rcount;
      m_full = (m_level == DEPTH);
      m_af = (m_level >= AFT);
      #1;
      check_regs();
   endtask

   task automatic async_reset();
      #3;
      reset = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0; rptr_gray_async = '0;
      model_reset();
      #1;
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      check_regs();
      repeat (2) @(posedge in_clk);
      @(negedge in_clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 0; wr_data = '0; clr_ovf = 0; rptr_gray_async = '0;
      model_reset();
      #2;
      check_regs();
      repeat (2) @(posedge in_clk);
      @(negedge in_clk);
      reset = 1'b0;

      // Fill from empty
      for (int i = 0; i < 8; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
      chk("t1_gray", 32'(wptr_gray), 32'h0000000C);
      chk("t1_full", 32'(fifo_f), 32'd1);
      chk("t1_level", 32'(wr_level), 32'd8);

      // Push while full, then clear overflow
      step(1'b1, 8'hFF, 1'b0);
      chk("t2_ovf", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      chk("t2_clr", 32'(overflow), 32'd0);
      // Set beats clear
      step(1'b1, 8'hEE, 1'b1);
      chk("t2_setwins", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b1);

      // One read frees a slot; visible on the third edge. Simultaneous push still rejected.
      rcount = 1;
      step(1'b1, 8'h11, 1'b0);
      chk("t3_full_e1", 32'(fifo_f), 32'd1);
      step(1'b0, 8'h00, 1'b0);
      chk("t3_full_e2", 32'(fifo_f), 32'd1);
      step(1'b0, 8'h00, 1'b0);
      chk("t3_full_e3", 32'(fifo_f), 32'd0);
      chk("t3_level", 32'(wr_level), 32'd7);
      step(1'b1, 8'h55, 1'b0);
      step(1'b0, 8'h00, 1'b1);

      // Drain, then stream with the reader two behind
      rcount = wcount;
      repeat (3) step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (wcount - 2 > rcount) rcount = wcount - 2;
         step(1'b1, 8'(i), 1'b0);
      end

      // Almost-full threshold from a clean start
      async_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
      chk("t5_af5", 32'(fifo_af), 32'd0);
      step(1'b1, 8'h35, 1'b0);
      chk("t5_af6", 32'(fifo_af), 32'd1);
      rcount = 1;
      repeat (3) step(1'b0, 8'h00, 1'b0);
      chk("t5_af_drop", 32'(fifo_af), 32'd0);

      // Reset mid-burst
      async_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
      @(negedge in_clk);
      wr_en = 1'b1;
      async_reset();
      step(1'b1, 8'h77, 1'b0);
      chk("t6_gray", 32'(wptr_gray), 32'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if (rcount < wcount && $urandom_range(0, 99) < 40) rcount++;
         step(1'($urandom_range(0, 99) < 65), 8'($urandom), 1'($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end
endmodule
